// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared types and helpers for the barrel rotator pipeline
package barrel_pkg;

    // Operation select carried alongside each word through the pipeline.
    typedef enum logic [1:0] {
        ROL = 2'b00,
        ROR = 2'b01,
        SHL = 2'b10,
        SHR = 2'b11
    } shift_op_t;

    // Shift-amount width (and pipeline depth) for a given data width.
    function automatic int amt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/barrel_rotator_stage.sv
// rtl/barrel_rotator_stage.sv - combinational shift/rotate by a fixed 2^K, gated by en
//
// Ports:
//   data_in  [W-1:0]  word entering this stage
//   op       2        operation (shift_op_t)
//   en       1        apply the 2^K shift when high, otherwise pass through
//   fill     1        bit used to fill vacated MSBs on a right shift
//   data_out [W-1:0]  shifted word
module barrel_rotator_stage
    import barrel_pkg::*;
#(
    parameter int W = 8,
    parameter int K = 0
) (
    input  logic [W-1:0] data_in,
    input  shift_op_t    op,
    input  logic         en,
    input  logic         fill,
    output logic [W-1:0] data_out
);

    localparam int S = 1 << K;

    always_comb begin
        data_out = data_in;
        if (en) begin
            case (op)
                ROL:     data_out = {data_in[W-S-1:0], data_in[W-1:W-S]};
                ROR:     data_out = {data_in[S-1:0], data_in[W-1:S]};
                SHL:     data_out = {data_in[W-S-1:0], {S{1'b0}}};
                SHR:     data_out = {{S{fill}}, data_in[W-1:S]};
                default: data_out = data_in;
            endcase
        end
    end

endmodule

// File: rtl/barrel_rotator_pipe.sv
// rtl/barrel_rotator_pipe.sv - pipelined barrel shifter/rotator with valid/ready on both sides
//
// Build option: SHIFT_ARITH_EN - when defined, op 11 is an arithmetic right shift.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   up_valid    input word valid
//   up_ready    block accepts input this cycle (combinational from down_ready)
//   up_data     input word [W-1:0]
//   up_amt      shift amount [SW-1:0]
//   up_op       00 rol, 01 ror, 10 logical left, 11 right shift
//   down_valid  result valid
//   down_ready  consumer accepts result
//   down_data   result word [W-1:0]
module barrel_rotator_pipe
    import barrel_pkg::*;
#(
    parameter  int W  = 8,
    localparam int SW = amt_width(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [W-1:0]  up_data,
    input  logic [SW-1:0] up_amt,
    input  logic [1:0]    up_op,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [W-1:0]  down_data
);

    // Stage k's register holds the word after shifts 2^0..2^k have been applied.
    logic [W-1:0]  data_q [SW];
    shift_op_t     op_q   [SW];
    logic [SW-1:0] amt_q  [SW];
    logic          vld_q  [SW];

    // Inputs to each stage's combinational shifter and its result.
    logic [W-1:0]  in_data  [SW];
    shift_op_t     in_op    [SW];
    logic [SW-1:0] in_amt   [SW];
    logic          in_vld   [SW];
    logic [W-1:0]  nxt_data [SW];
    logic [SW-1:0] fill;

    logic adv;

    assign down_valid = vld_q[SW-1];
    assign down_data  = data_q[SW-1];

    // The whole pipe moves as one unit; a stalled output freezes every stage.
    assign adv      = down_ready | ~down_valid;
    assign up_ready = adv;

`ifdef SHIFT_ARITH_EN
    // The original MSB travels with the word so that later stages fill with
    // the true sign even after earlier stages have shifted it out of place.
    logic sign_q  [SW];
    logic in_sign [SW];

    for (genvar k = 0; k < SW; k++) begin : g_sign
        if (k == 0) begin : g_first
            assign in_sign[k] = up_data[W-1];
        end else begin : g_next
            assign in_sign[k] = sign_q[k-1];
        end
        assign fill[k] = in_sign[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SW; k++) begin
                sign_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < SW; k++) begin
                sign_q[k] <= in_sign[k];
            end
        end
    end
`else
    assign fill = '0;
`endif

    for (genvar k = 0; k < SW; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign in_data[k] = up_data;
            assign in_op[k]   = shift_op_t'(up_op);
            assign in_amt[k]  = up_amt;
            assign in_vld[k]  = up_valid;
        end else begin : g_next
            assign in_data[k] = data_q[k-1];
            assign in_op[k]   = op_q[k-1];
            assign in_amt[k]  = amt_q[k-1];
            assign in_vld[k]  = vld_q[k-1];
        end

        barrel_rotator_stage #(
            .W (W),
            .K (k)
        ) u_stage (
            .data_in  (in_data[k]),
            .op       (in_op[k]),
            .en       (in_amt[k][k]),
            .fill     (fill[k]),
            .data_out (nxt_data[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SW; k++) begin
                data_q[k] <= '0;
                op_q[k]   <= ROL;
                amt_q[k]  <= '0;
                vld_q[k]  <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < SW; k++) begin
                data_q[k] <= nxt_data[k];
                op_q[k]   <= in_op[k];
                amt_q[k]  <= in_amt[k];
                vld_q[k]  <= in_vld[k];
            end
        end
    end

endmodule

// File: tb/tb_barrel_rotator_pipe.sv
// tb/tb_barrel_rotator_pipe.sv - self-checking bench for barrel_rotator_pipe (W = 8)
module tb_barrel_rotator_pipe;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          up_valid;
    logic          up_ready;
    logic [W-1:0]  up_data;
    logic [SW-1:0] up_amt;
    logic [1:0]    up_op;
    logic          down_valid;
    logic          down_ready;
    logic [W-1:0]  down_data;

    int errors = 0;
    int checks = 0;

    barrel_rotator_pipe #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_amt     (up_amt),
        .up_op      (up_op),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: rotates via a doubled word, shifts via plain operators.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [SW-1:0] a,
                                           input logic [1:0] op);
        logic [2*W-1:0] t;
        case (op)
            2'b00: begin t = {d, d} << a; return t[2*W-1:W]; end
            2'b01: begin t = {d, d} >> a; return t[W-1:0]; end
            2'b10: return d << a;
            default: begin
`ifdef SHIFT_ARITH_EN
                return W'($signed(d) >>> a);
`else
                return d >> a;
`endif
            end
        endcase
    endfunction

    logic [W-1:0] exp_q[$];
    logic [W-1:0] log_q[$];
    int           log_cyc[$];
    int           cyc = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    // Scoreboard: observes both transfers every cycle between clock edges.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", down_valid, 1);
                check("stall_data", down_data, prev_data);
            end
            if (down_valid && down_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", down_data);
                end else begin
                    check("stream_data", down_data, exp_q.pop_front());
                end
                log_q.push_back(down_data);
                log_cyc.push_back(cyc);
            end
            if (up_valid && up_ready) exp_q.push_back(model(up_data, up_amt, up_op));
            prev_stall = down_valid && !down_ready;
            prev_data  = down_data;
        end
    end

    task automatic push(input logic [W-1:0] d, input logic [SW-1:0] a, input logic [1:0] op);
        logic acc;
        int   guard;
        up_valid = 1'b1;
        up_data  = d;
        up_amt   = a;
        up_op    = op;
        guard    = 0;
        do begin
            @(negedge clk);
            acc = up_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 300);
        up_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got not accepted expected accepted");
        end
    endtask

    task automatic wait_log(input int n);
        int guard = 0;
        while (log_q.size() < n && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("log_count", log_q.size(), n);
    endtask

    task automatic clear_log();
        log_q.delete();
        log_cyc.delete();
    endtask

    logic [W-1:0] sweep_exp [8];
    logic         stop_toggle = 1'b0;

    initial begin
        sweep_exp = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
        rst_n      = 1'b0;
        up_valid   = 1'b0;
        up_data    = '0;
        up_amt     = '0;
        up_op      = 2'b00;
        down_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_down_valid", down_valid, 0);
        check("reset_down_data", down_data, 0);
        check("reset_up_ready", up_ready, 1);

        // Latency: accept edge is edge 1, result visible after edge 3.
        up_valid = 1'b1;
        up_data  = 8'hA3;
        up_amt   = 3'd3;
        up_op    = 2'b01;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        check("lat_edge1", down_valid, 0);
        @(posedge clk);
        #1;
        check("lat_edge2", down_valid, 0);
        @(posedge clk);
        #1;
        check("lat_edge3", down_valid, 1);
        check("ror3_a3", down_data, 8'h74);
        repeat (2) @(posedge clk);
        #1;

        clear_log();
        push(8'hA3, 3'd3, 2'b00);
        wait_log(1);
        check("rol3_a3", log_q[0], 8'h1D);

        clear_log();
        push(8'hA3, 3'd3, 2'b11);
        wait_log(1);
`ifdef SHIFT_ARITH_EN
        check("sar3_a3", log_q[0], 8'hF4);
`else
        check("shr3_a3", log_q[0], 8'h14);
`endif

        clear_log();
        for (int i = 0; i < 4; i++) push(8'hC5, 3'd0, 2'(i));
        wait_log(4);
        for (int i = 0; i < 4; i++) check("amt0_c5", log_q[i], 8'hC5);

        clear_log();
        for (int i = 0; i < 8; i++) push(8'h01, 3'(i), 2'b01);
        wait_log(8);
        for (int i = 0; i < 8; i++) check("sweep_ror", log_q[i], sweep_exp[i]);
        check("sweep_b2b", log_cyc[7] - log_cyc[0], 7);

        // Random stream with pseudo-random backpressure.
        clear_log();
        fork
            begin
                while (!stop_toggle) begin
                    @(posedge clk);
                    #1;
                    down_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 16; i++)
            push(W'($urandom), SW'($urandom), 2'($urandom));
        begin
            int guard = 0;
            while ((exp_q.size() != 0 || down_valid) && guard < 500) begin
                @(posedge clk);
                #1;
                guard++;
            end
        end
        stop_toggle = 1'b1;
        @(posedge clk);
        #2;
        down_ready = 1'b1;
        check("stream_count", log_q.size(), 16);
        check("stream_drained", exp_q.size(), 0);

        // Fill with three words under stall, then reset.
        clear_log();
        down_ready = 1'b0;
        push(8'h11, 3'd1, 2'b00);
        push(8'h22, 3'd2, 2'b01);
        push(8'h33, 3'd3, 2'b10);
        check("fill_full", down_valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("flush_down_valid", down_valid, 0);
        check("flush_down_data", down_data, 0);
        check("flush_up_ready", up_ready, 1);
        down_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("flush_none", log_q.size(), 0);

        // Stall: up_ready follows down_ready combinationally.
        clear_log();
        push(8'h96, 3'd2, 2'b00);
        begin
            int guard = 0;
            while (!down_valid && guard < 20) begin
                @(posedge clk);
                #1;
                guard++;
            end
        end
        down_ready = 1'b0;
        #1;
        check("stall_same_cycle", up_ready, 0);
        up_valid = 1'b1;
        up_data  = 8'h5A;
        up_amt   = 3'd5;
        up_op    = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_no_accept", up_ready, 0);
        end
        @(posedge clk);
        #1;
        down_ready = 1'b1;
        #1;
        check("ready_rise", up_ready, 1);
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        wait_log(2);
        check("stall_first", log_q[0], 8'h5A);
`ifdef SHIFT_ARITH_EN
        check("stall_second", log_q[1], 8'h02);
`else
        check("stall_second", log_q[1], 8'h02);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
